echo_comb: RTL

- Feedback (IIR comb) echo generator for the echo machine datapath. It is the recursive counterpart of the feed-forward FIR stage.
- Accepts one signed 16-bit sample per valid/ready handshake.
- Computes y[n] = x[n] + g*y[n-D] using a circular sample buffer.
- Presents the result on a valid/ready output toward the codec/output stage.

---
 rtl/echo_comb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/echo_comb.sv
// echo_comb: feedback comb echo y[n] = x[n] + g*y[n-D] over a circular sample buffer.
// Optional feature macro ECHO_BYPASS_EN adds a per-sample bypass input that forces y = x.
module echo_comb #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  input  logic [AW-1:0] delay_len,
  input  logic [15:0]   gain,
`ifdef ECHO_BYPASS_EN
  input  logic          bypass,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_sample
);

  localparam int unsigned PW = DW + 16;
  localparam logic [AW:0]    FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [DW-1:0]  SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]  SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic                 w_accept;
  logic                 w_xfer;

  logic signed [DW-1:0] r_x;
  logic [AW-1:0]        r_d;
  logic signed [15:0]   r_g;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW:0]          r_fill;
  logic signed [DW-1:0] r_rdata;
  logic signed [DW-1:0] r_y;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DW-1:0]        r_out_sample;
  logic [DW-1:0]        r_mem [DEPTH];

  logic [AW-1:0]        w_rd_addr;
  logic signed [DW-1:0] w_fb;
  logic signed [PW-1:0] w_prod;
  logic signed [DW:0]   w_scaled;
  logic signed [DW:0]   w_sum;
  logic signed [DW-1:0] w_sat;
  logic signed [DW-1:0] w_y;

`ifdef ECHO_BYPASS_EN
  logic                 r_byp;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_xfer   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = in_valid && r_in_ready;
        if (w_accept) w_next = S_READ;
      end
      S_READ:  w_next = S_CALC;
      S_CALC:  w_next = S_WRITE;
      S_WRITE: w_next = S_OUT;
      S_OUT: begin
        w_xfer = r_out_valid && out_ready;
        if (w_xfer) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Feedback tap only counts once the buffer holds D samples written since reset
  always_comb begin
    w_rd_addr = r_wr_ptr - r_d;
    w_fb      = ((r_d != '0) && ({1'b0, r_d} <= r_fill)) ? r_rdata : '0;
    w_prod    = w_fb * r_g;
    w_scaled  = (DW+1)'(w_prod >>> 15);
    w_sum     = (DW+1)'(r_x) + w_scaled;
    w_sat     = w_sum[DW-1:0];
    if (w_sum[DW] != w_sum[DW-1]) w_sat = w_sum[DW] ? SAT_MIN : SAT_MAX;
`ifdef ECHO_BYPASS_EN
    w_y       = r_byp ? r_x : w_sat;
`else
    w_y       = w_sat;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x          <= '0;
      r_d          <= '0;
      r_g          <= '0;
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_y          <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
`ifdef ECHO_BYPASS_EN
      r_byp        <= 1'b0;
`endif
    end else begin
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (r_state == S_OUT) && !w_xfer;
      if (w_accept) begin
        r_x <= in_sample;
        r_d <= delay_len;
        r_g <= gain;
`ifdef ECHO_BYPASS_EN
        r_byp <= bypass;
`endif
      end
      if (r_state == S_CALC) r_y <= w_y;
      if (r_state == S_WRITE) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_out_sample <= r_y;
        if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Sample buffer: not cleared by reset
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_mem[r_wr_ptr] <= r_y;
    if (r_state == S_READ)  r_rdata <= r_mem[w_rd_addr];
  end

endmodule
